// File: rtl/axis_sync_fifo_pkt_downsizer.sv
// Single-clock AXI-stream FIFO with integer-ratio output downsizing, optional
// store-and-forward packet mode, and registered occupancy / packet-count status.
module axis_sync_fifo_pkt_downsizer #(
  parameter int TDataWidth    = 32,
  parameter int DownSizeRatio = 1,
  parameter int TidWidth      = 8,
  parameter int TdestWidth    = 8,
  parameter int AddressWidth  = 3,
  parameter int PacketMode    = 0
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_arstn,
  input  logic [TidWidth-1:0]                   s_axis_tid,
  input  logic [TdestWidth-1:0]                 s_axis_tdest,
  input  logic [TDataWidth-1:0]                 s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  output logic                                  s_axis_tready,
  output logic [TidWidth-1:0]                   m_axis_tid,
  output logic [TdestWidth-1:0]                 m_axis_tdest,
  output logic [TDataWidth/DownSizeRatio-1:0]   m_axis_tdata,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [AddressWidth:0]                 fill_level,
  output logic [AddressWidth:0]                 pkt_count
);
  localparam int MTDataWidth = TDataWidth / DownSizeRatio;
  localparam int FifoDepth   = 2 ** AddressWidth;
  localparam int EntryWidth  = TidWidth + TdestWidth + TDataWidth + 1;
  localparam int SliceWidth  = (DownSizeRatio > 1) ? $clog2(DownSizeRatio) : 1;
  localparam int CntWidth    = AddressWidth + 1;
  localparam logic [SliceWidth-1:0] LastSlice = SliceWidth'(DownSizeRatio - 1);
  localparam logic [CntWidth-1:0]   FullLevel = CntWidth'(FifoDepth);

  logic [EntryWidth-1:0]   r_mem [FifoDepth];
  logic [AddressWidth-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntWidth-1:0]     r_fill, r_pkt;
  logic                    r_s_ready;
  logic                    r_head_valid, r_head_last;
  logic [TidWidth-1:0]     r_head_tid;
  logic [TdestWidth-1:0]   r_head_tdest;
  logic [TDataWidth-1:0]   r_head_data;
  logic [SliceWidth-1:0]   r_slice;
  logic                    r_in_pkt, r_escape;

  logic                    w_wr, w_slice_hs, w_retire, w_tlast_hs;
  logic                    w_mem_has_word, w_escape_trig, w_pkt_ready, w_allow, w_load;
  logic [CntWidth-1:0]     w_fill_nxt, w_pkt_nxt;
  logic [TidWidth-1:0]     w_rd_tid;
  logic [TdestWidth-1:0]   w_rd_tdest;
  logic [TDataWidth-1:0]   w_rd_tdata;
  logic                    w_rd_tlast;

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_head_valid;
  assign m_axis_tid    = r_head_tid;
  assign m_axis_tdest  = r_head_tdest;
  assign m_axis_tdata  = r_head_data[r_slice * MTDataWidth +: MTDataWidth];
  assign m_axis_tlast  = r_head_last & (r_slice == '0);
  assign fill_level    = r_fill;
  assign pkt_count     = r_pkt;

  assign w_wr       = s_axis_tvalid & r_s_ready;
  assign w_slice_hs = r_head_valid & m_axis_tready;
  assign w_retire   = w_slice_hs & (r_slice == '0);
  assign w_tlast_hs = w_slice_hs & m_axis_tlast;

  assign w_fill_nxt = r_fill + CntWidth'(w_wr) - CntWidth'(w_retire);
  assign w_pkt_nxt  = r_pkt + CntWidth'(w_wr & s_axis_tlast) - CntWidth'(w_tlast_hs);

  // fill_level includes the head register, so words still in memory are the difference.
  assign w_mem_has_word = (r_fill - CntWidth'(r_head_valid)) != '0;

  // A packet finishing this cycle no longer counts as available for the next load.
  assign w_escape_trig = (r_fill == FullLevel) && (r_pkt == '0);
  assign w_pkt_ready   = (r_pkt - CntWidth'(w_tlast_hs)) != '0;
  assign w_allow       = (PacketMode == 0) || w_pkt_ready || r_in_pkt ||
                         (r_escape && !w_tlast_hs) || w_escape_trig;

  assign w_load = w_mem_has_word && (!r_head_valid || w_retire) && w_allow;

  assign {w_rd_tid, w_rd_tdest, w_rd_tdata, w_rd_tlast} = r_mem[r_rd_ptr];

  always_ff @(posedge axis_aclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {s_axis_tid, s_axis_tdest, s_axis_tdata, s_axis_tlast};
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_arstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_pkt        <= '0;
      r_s_ready    <= 1'b0;
      r_head_valid <= 1'b0;
      r_head_last  <= 1'b0;
      r_head_tid   <= '0;
      r_head_tdest <= '0;
      r_head_data  <= '0;
      r_slice      <= LastSlice;
      r_in_pkt     <= 1'b0;
      r_escape     <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + AddressWidth'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AddressWidth'(1);
      r_fill    <= w_fill_nxt;
      r_pkt     <= w_pkt_nxt;
      r_s_ready <= (w_fill_nxt != FullLevel);

      if (w_load) begin
        r_head_valid <= 1'b1;
        r_head_tid   <= w_rd_tid;
        r_head_tdest <= w_rd_tdest;
        r_head_data  <= w_rd_tdata;
        r_head_last  <= w_rd_tlast;
        r_slice      <= LastSlice;
        r_in_pkt     <= ~w_rd_tlast;
      end else if (w_retire) begin
        r_head_valid <= 1'b0;
        r_slice      <= LastSlice;
      end else if (w_slice_hs) begin
        r_slice <= r_slice - SliceWidth'(1);
      end

      if (w_tlast_hs)                          r_escape <= 1'b0;
      else if (PacketMode != 0 && w_escape_trig) r_escape <= 1'b1;
    end
  end
endmodule

// File: doc/axis_sync_fifo_pkt_downsizer.md
Name: axis_sync_fifo_pkt_downsizer

Overview:
Single-clock AXI-stream FIFO, the parametrised successor of the async FIFO AXIS wrapper, for intra-domain buffering in front of narrower links. It adds three things:
- output width downsizing by an integer ratio;
- an optional store-and-forward packet mode;
- occupancy and packet-count status outputs.

It sits between an AXIS producer (NI or router port) and a narrower AXIS consumer on the same clock.

Parameters:
- TDataWidth, 32: slave (input) tdata width in bits.
- DownSizeRatio, 1: master beats per input word. Must divide TDataWidth; master width MTDataWidth = TDataWidth/DownSizeRatio.
- TidWidth, 8: tid width.
- TdestWidth, 8: tdest width.
- AddressWidth, 3: FIFO depth is FifoDepth = 2**AddressWidth input words.
- PacketMode, 0: 0 = cut-through; 1 = store-and-forward.

Ports:
- axis_aclk  in  1  clock for both interfaces.
- axis_arstn  in  1  reset, synchronous, active-low.
- s_axis_tid  in  TidWidth  stream id.
- s_axis_tdest  in  TdestWidth  destination.
- s_axis_tdata  in  TDataWidth  payload.
- s_axis_tvalid  in  1  producer valid.
- s_axis_tlast  in  1  packet boundary.
- s_axis_tready  out  1  FIFO can accept a word.
- m_axis_tid  out  TidWidth  id of current word.
- m_axis_tdest  out  TdestWidth  dest of current word.
- m_axis_tdata  out  MTDataWidth  current slice.
- m_axis_tvalid  out  1  slice valid.
- m_axis_tlast  out  1  last slice of a tlast word.
- m_axis_tready  in  1  consumer ready.
- fill_level  out  AddressWidth+1  words held, 0..FifoDepth.
- pkt_count  out  AddressWidth+1  complete packets held.

Behaviour:
- Reset (axis_arstn low at a rising edge):
  - From that edge: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tid/tdest=0, fill_level=0, pkt_count=0, slice index=DownSizeRatio-1.
  - All stored data is discarded, including on reset mid-packet or mid-word.
  - s_axis_tready rises the first edge after axis_arstn is sampled high.
- Write: accepted when s_axis_tvalid & s_axis_tready at an edge. Stores {tid, tdest, tdata, tlast}.
  - s_axis_tready = (fill_level != FifoDepth).
  - Registered; never combinationally dependent on m_axis_tready.
- Read path: first-word-fall-through with a registered head word.
  - Cut-through, empty FIFO: a word accepted at edge k gives m_axis_tvalid=1 after edge k+1 (1-cycle latency).
- Downsizing:
  - Each word is emitted as DownSizeRatio slices, most-significant slice first: slice index DownSizeRatio-1 down to 0. Slice i = tdata[i*MTDataWidth +: MTDataWidth].
  - tid and tdest are held constant across all slices of the word.
  - m_axis_tlast = stored tlast & (slice index == 0).
  - A slice advances on m_axis_tvalid & m_axis_tready.
  - The word is retired (pops, fill_level decrements) on the handshake of slice 0.
  - Next word follows with no bubble if available: back-to-back throughput is 1 slice/cycle.
  - DownSizeRatio=1 degenerates to a plain FIFO.
- AXIS rules: once m_axis_tvalid=1, it and all m_axis payload signals hold until the handshake. The master side never withdraws valid.
- fill_level:
  - +1 per accepted write, -1 per retired word; a simultaneous write and retire leaves it unchanged.
  - Counts the head word until it is retired.
- pkt_count:
  - +1 on an accepted write with s_axis_tlast=1.
  - -1 on the handshake of a slice carrying m_axis_tlast=1.
  - Simultaneous increment and decrement leaves it unchanged.
- PacketMode=1:
  - The head word is presented only while pkt_count>0, or while the current packet has already begun output.
  - Deadlock escape: when fill_level==FifoDepth and pkt_count==0, the block switches to cut-through until the next m_axis_tlast handshake.
- Full boundary: a write offered while full is not accepted and is held by the producer. A retire and an incoming write in the same cycle while full: the write is not accepted that cycle and is accepted the next.
- Pointers: AddressWidth-bit, natural wrap-around modulo FifoDepth.
- Status outputs are registered and valid the cycle after the causing edge.

Test Plan:
- Reset released with DownSizeRatio=1, PacketMode=0: s_axis_tready=1 one cycle after release. Write 0xA5A5_0001 with tid=3, tdest=7 → m_axis_tvalid one cycle later with the same tdata/tid/tdest, and fill_level goes 1→0 after the read.
- Fill/flush, depth 8, m_axis_tready=0: attempt 17 writes → exactly 8 accepted, s_axis_tready=0, fill_level=8. Drain → 8 words in order, fill_level=0, m_axis_tvalid=0.
- DownSizeRatio=4, TDataWidth=32: write 0x11223344 with tlast=1 → four slices 0x11, 0x22, 0x33, 0x44, m_axis_tlast only on 0x44, identical tid on all four.
- PacketMode=1, m_axis_tready=1: write 3 words, tlast on the 3rd → m_axis_tvalid stays 0 until after the tlast write, then 3 back-to-back beats; pkt_count goes 1→0.
- PacketMode=1, 10-word packet into depth 8 → escape after 8 words held, all 10 words delivered in order, no deadlock.
- Reset asserted mid-stream with 5 words held → next cycle fill_level=0, pkt_count=0, m_axis_tvalid=0. After release, new data is returned with no stale words.
